// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out shifter with a ready/valid word
// input, a pausable serial output carrying frame markers, and a count of
// completed words.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no word in flight; in_ready high, serial outputs low
// SHIFT | word in flight; one bit is consumed per edge while pause is low

module piso_serializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             dir,
  input  logic             pause,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic [7:0]       words_sent
);

  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [IDX_W-1:0] bit_idx;
  logic             dir_q;
  logic             valid_q;

  logic             at_last;
  logic             advance;
  logic             accept;

  // The last bit is being consumed at the coming edge only when not paused.
  always_comb begin
    at_last = (bit_idx == LAST_IDX);
    advance = (state == SHIFT) && !pause;
  end

  // Ready while idle, or on the final-bit cycle so the next word follows
  // without a gap; forced low while clear is asserted.
  always_comb begin
    in_ready = 1'b0;
    if (clear) begin
      in_ready = (state == IDLE) || ((state == SHIFT) && at_last && !pause);
    end
    accept = in_valid && in_ready;
  end

  // Pause masks the qualifiers but not serial_out, which keeps the held bit.
  always_comb begin
    serial_valid = valid_q && !pause;
    frame_start  = serial_valid && (bit_idx == '0);
    frame_end    = serial_valid && at_last;
  end

  // Word counter: bumps on every consumed final bit, wrapping at 256.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      words_sent <= 8'd0;
    end else if (advance && at_last) begin
      words_sent <= words_sent + 8'd1;
    end
  end

  // Sequencer: loads accepted words, shifts toward the output end, and
  // registers the bit that will be presented in the next cycle.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_idx    <= '0;
      dir_q      <= 1'b0;
      valid_q    <= 1'b0;
      serial_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= SHIFT;
            shift_reg  <= in_data;
            dir_q      <= dir;
            bit_idx    <= '0;
            valid_q    <= 1'b1;
            serial_out <= dir ? in_data[WIDTH-1] : in_data[0];
          end
        end
        SHIFT: begin
          if (accept) begin
            // Back-to-back: next word replaces the finished one at once.
            shift_reg  <= in_data;
            dir_q      <= dir;
            bit_idx    <= '0;
            valid_q    <= 1'b1;
            serial_out <= dir ? in_data[WIDTH-1] : in_data[0];
          end else if (advance) begin
            if (at_last) begin
              state      <= IDLE;
              shift_reg  <= '0;
              bit_idx    <= '0;
              valid_q    <= 1'b0;
              serial_out <= 1'b0;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
              if (dir_q) begin
                shift_reg  <= shift_reg << 1;
                serial_out <= shift_reg[WIDTH-2];
              end else begin
                shift_reg  <= shift_reg >> 1;
                serial_out <= shift_reg[1];
              end
            end
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter: WIDTH, default 4, parallel word width in bits; legal range 2..16.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: clear  input  1  asynchronous, active-low reset.
REQ-004 Port: in_data  input  WIDTH  parallel word to serialize.
REQ-005 Port: in_valid  input  1  in_data holds a word for transfer.
REQ-006 Port: in_ready  output  1  block can accept a word this cycle (combinational).
REQ-007 Port: dir  input  1  bit order, sampled with the word: 1 = MSB first (left shift), 0 = LSB first (right shift).
REQ-008 Port: pause  input  1  stall request; freezes shifting.
REQ-009 Port: serial_out  output  1  current serial bit.
REQ-010 Port: serial_valid  output  1  serial_out is valid and is consumed at this rising edge.
REQ-011 Port: frame_start  output  1  current bit is bit 0 of a word.
REQ-012 Port: frame_end  output  1  current bit is the last bit of a word.
REQ-013 Port: words_sent  output  8  count of completed words, modulo 256.

Function
REQ-014 States: IDLE and SHIFT. The block holds a WIDTH-bit shift register, a bit index of ceil(log2(WIDTH)) bits, a latched dir bit, and an internal valid flag valid_q.
REQ-015 A word is accepted at a rising edge where in_valid=1 and in_ready=1.
REQ-016 in_ready = 1 in IDLE, and also 1 in SHIFT when bit index = WIDTH-1 and pause = 0. It is 0 otherwise and 0 while clear = 0.
REQ-017 On acceptance, the block loads in_data and dir, sets bit index to 0, sets valid_q to 1, and enters SHIFT. The first bit (MSB if dir=1, LSB if dir=0) appears on serial_out in the cycle after the accept edge.
REQ-018 serial_valid = valid_q AND NOT pause. frame_start and frame_end are also forced to 0 whenever serial_valid = 0.
REQ-019 In SHIFT, at each edge with pause = 0 and bit index < WIDTH-1, the register shifts toward the output end, serial_out shows the next bit, and the bit index increments.
REQ-020 In SHIFT, at an edge with pause = 0 and bit index = WIDTH-1:
- words_sent increments, wrapping from 255 to 0.
- If a word is accepted at the same edge, the new word loads per REQ-017 with no idle cycle between words.
- Otherwise, the block enters IDLE, and valid_q, serial_out, frame_start and frame_end are 0 after the edge.
REQ-021 While pause = 1 in SHIFT, the shift register, bit index, dir, serial_out and words_sent hold their values, and no bit is consumed.
REQ-022 An accept in IDLE while pause = 1 is legal. The word loads, and the first bit is held masked until pause = 0.
REQ-023 frame_start = serial_valid AND (bit index = 0). frame_end = serial_valid AND (bit index = WIDTH-1).
REQ-024 in_data and dir changing during SHIFT have no effect on the word in flight.
REQ-025 Each word produces exactly WIDTH consumed bits. No bit is dropped or duplicated across pauses or back-to-back words.

Reset
REQ-026 clear = 0 immediately and asynchronously forces: IDLE, shift register = 0, bit index = 0, valid_q = 0, serial_out = 0, serial_valid = 0, frame_start = 0, frame_end = 0, words_sent = 0, in_ready = 0.
REQ-027 clear asserted mid-word discards the partial word and does not count it. After clear returns to 1, in_ready = 1 and operation resumes at the first rising edge.

Verification (WIDTH=4)
REQ-028 MSB first: in_data=1101, dir=1, one accept -> consumed bits 1,1,0,1; frame_start on bit 1 only; frame_end on bit 4 only; words_sent 0->1.
REQ-029 LSB first: in_data=1101, dir=0 -> consumed bits 1,0,1,1; the block then returns to IDLE with serial_valid=0.
REQ-030 Back-to-back: 1101 (dir=1), then 0110 (dir=0) accepted on the last-bit edge -> 8 contiguous valid bits 1,1,0,1,0,1,1,0; frame_end then frame_start on adjacent cycles; words_sent=2.
REQ-031 Pause: 1101 (dir=1), pause high for 3 cycles after the 2nd bit -> serial_valid=0 for those 3 cycles, serial_out holds 0, and the stream resumes with 0,1.
REQ-032 Reset mid-word: clear low after the 2nd bit of 1101 -> all outputs 0 immediately and words_sent=0; a new word 0011 (dir=1) afterward -> bits 0,0,1,1.
REQ-033 Wrap: 256 consecutive words -> words_sent reads 255, then 0 after the 256th word's last bit.
